// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_send transmitter between NUM_REQ byte producers.
// uart_send has no busy flag, so each frame (plus a guard gap) is timed locally before re-arbitrating.
module uart_tx_arbiter #(
  parameter int unsigned baudRate     = 115200,
  parameter int unsigned clkFreq      = 100000000,
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned GUARD_CYCLES = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   reqData,
  output logic [NUM_REQ-1:0]     grant,
  output logic [7:0]             data,
  output logic                   send_trigger,
  output logic                   busy
);

  localparam int unsigned BIT_CYCLES   = clkFreq / baudRate;
  localparam int unsigned FRAME_CYCLES = 10 * BIT_CYCLES + GUARD_CYCLES;
  localparam int unsigned CNT_W        = $clog2(FRAME_CYCLES);
  localparam int unsigned PTR_W        = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_TRIGGER = 2'd1,
    S_WAIT    = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   win_q, win_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [7:0]         data_q, data_d;
  logic               send_trigger_q, send_trigger_d;
  logic               busy_q, busy_d;

  logic               found_c;
  logic [PTR_W-1:0]   win_c;
  logic [PTR_W-1:0]   cand_c;
  logic [7:0]         win_byte_c;
  int unsigned        idx_c;

  // First asserted request at or after the round-robin pointer, wrapping modulo NUM_REQ.
  always_comb begin
    found_c = 1'b0;
    win_c   = '0;
    cand_c  = '0;
    idx_c   = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx_c  = (32'(rr_ptr_q) + i) % NUM_REQ;
      cand_c = PTR_W'(idx_c);
      if (!found_c && req[cand_c]) begin
        found_c = 1'b1;
        win_c   = cand_c;
      end
    end
  end

  always_comb begin
    win_byte_c = 8'h00;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (win_c == PTR_W'(j)) begin
        win_byte_c = reqData[8*j +: 8];
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    rr_ptr_d       = rr_ptr_q;
    win_d          = win_q;
    grant_d        = '0;
    data_d         = data_q;
    send_trigger_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (found_c) begin
          win_d          = win_c;
          data_d         = win_byte_c;
          grant_d        = NUM_REQ'(1) << win_c;
          send_trigger_d = 1'b1;
          state_d        = S_TRIGGER;
        end
      end
      S_TRIGGER: begin
        cnt_d    = '0;
        rr_ptr_d = (win_q == PTR_LAST) ? '0 : win_q + PTR_W'(1);
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        // Requests are ignored here; uart_send is still shifting the frame out.
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      rr_ptr_q       <= '0;
      win_q          <= '0;
      grant_q        <= '0;
      data_q         <= 8'h00;
      send_trigger_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      rr_ptr_q       <= rr_ptr_d;
      win_q          <= win_d;
      grant_q        <= grant_d;
      data_q         <= data_d;
      send_trigger_q <= send_trigger_d;
      busy_q         <= busy_d;
    end
  end

  assign grant        = grant_q;
  assign data         = data_q;
  assign send_trigger = send_trigger_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random traffic against a frame-timing model
// (next eligible arbitration edge, round-robin pointer) built from the arbitration rules.
module tb_uart_tx_arbiter;

  localparam int BAUD  = 100;
  localparam int CLKF  = 1000;
  localparam int NREQ  = 4;
  localparam int IW    = 2;
  localparam int GUARD = 4;
  localparam int FRAME = 10 * (CLKF / BAUD) + GUARD;
  localparam int PERIOD = FRAME + 2;

  typedef enum int {M_DROP, M_FAIR, M_SWEEP, M_RAND} mode_e;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req;
  logic [8*NREQ-1:0]   req_data;
  logic [NREQ-1:0]     grant;
  logic [7:0]          data;
  logic                send_trigger;
  logic                busy;

  uart_tx_arbiter #(
    .baudRate     (BAUD),
    .clkFreq      (CLKF),
    .NUM_REQ      (NREQ),
    .GUARD_CYCLES (GUARD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .reqData      (req_data),
    .grant        (grant),
    .data         (data),
    .send_trigger (send_trigger),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  mode_e           mode;
  logic [7:0]      bytes [NREQ];
  int              edge_n = 0;
  int              next_sample = 0;
  int              ptr = 0;
  logic [NREQ-1:0] exp_grant;
  logic            exp_trig;
  logic            exp_busy;
  logic [7:0]      exp_data;
  logic            spacing_on;
  int              last_dut_trig;
  logic [NREQ-1:0] fair_exp;
  logic [7:0]      rx [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  task automatic update_data();
    for (int i = 0; i < NREQ; i++) req_data[8*i +: 8] = bytes[IW'(i)];
  endtask

  // Predict the outputs after the coming edge from the inputs that edge will sample.
  task automatic model();
    int w;
    int idx;
    edge_n++;
    exp_grant = '0;
    exp_trig  = 1'b0;
    if (rst) begin
      exp_data    = 8'h00;
      exp_busy    = 1'b0;
      ptr         = 0;
      next_sample = edge_n + 1;
    end else begin
      if (edge_n >= next_sample && req != '0) begin
        w = -1;
        for (int k = 0; k < NREQ; k++) begin
          idx = (ptr + k) % NREQ;
          if (w < 0 && req[IW'(idx)]) w = idx;
        end
        exp_grant[IW'(w)] = 1'b1;
        exp_trig    = 1'b1;
        exp_data    = bytes[IW'(w)];
        ptr         = (w + 1) % NREQ;
        next_sample = edge_n + PERIOD;
      end
      exp_busy = (edge_n < next_sample - 1);
    end
  endtask

  task automatic check_outputs();
    check("grant", 32'(grant), 32'(exp_grant));
    check("send_trigger", 32'(send_trigger), 32'(exp_trig));
    check("data", 32'(data), 32'(exp_data));
    check("busy", 32'(busy), 32'(exp_busy));
    if (send_trigger) begin
      rx.push_back(data);
      if (spacing_on && last_dut_trig >= 0) check("trigger_spacing", 32'(edge_n - last_dut_trig), 32'(PERIOD));
      last_dut_trig = edge_n;
      if (mode == M_FAIR) begin
        check("fair_winner", 32'(grant), 32'(fair_exp));
        fair_exp = fair_exp ^ 4'b0011;
      end
    end
  endtask

  // Requester behaviour; reacts to the grant pulse seen in the current cycle.
  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      case (mode)
        M_DROP: if (grant[IW'(i)]) req[IW'(i)] = 1'b0;
        M_FAIR: if (grant[IW'(i)]) bytes[IW'(i)] = bytes[IW'(i)] + 8'd1;
        M_SWEEP: begin
          if (i == 0 && grant[0]) begin
            if (bytes[0] == 8'hFF) req[0] = 1'b0;
            else bytes[0] = bytes[0] + 8'd1;
          end
        end
        default: begin
          if (grant[IW'(i)]) begin
            if ($urandom_range(1, 0) == 1) bytes[IW'(i)] = 8'($urandom);
            else req[IW'(i)] = 1'b0;
          end else if (req[IW'(i)]) begin
            if ($urandom_range(999, 0) == 0) req[IW'(i)] = 1'b0;
          end else if ($urandom_range(59, 0) == 0) begin
            req[IW'(i)]   = 1'b1;
            bytes[IW'(i)] = 8'($urandom);
          end
        end
      endcase
    end
    if (mode == M_RAND) rst = ($urandom_range(4999, 0) == 0);
    update_data();
  endtask

  task automatic cycle();
    model();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    drive();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic do_reset();
    req = '0;
    update_data();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    last_dut_trig = -1;
    fair_exp      = 4'b0001;
    spacing_on    = 1'b0;
  endtask

  initial begin
    mode          = M_DROP;
    spacing_on    = 1'b0;
    last_dut_trig = -1;
    fair_exp      = 4'b0001;
    for (int i = 0; i < NREQ; i++) bytes[IW'(i)] = 8'h00;
    req = '0;
    update_data();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    run(3);

    // single request from source 2
    bytes[2] = 8'hA5;
    req      = 4'b0100;
    update_data();
    run(PERIOD + 10);

    // all four requesting, each drops after its grant
    do_reset();
    for (int i = 0; i < NREQ; i++) bytes[IW'(i)] = 8'(8'h10 + i);
    req        = 4'b1111;
    spacing_on = 1'b1;
    update_data();
    run(4 * PERIOD + 10);

    // fairness: source 0 always requesting, source 1 re-presents after each grant
    do_reset();
    mode     = M_FAIR;
    bytes[0] = 8'h40;
    bytes[1] = 8'h80;
    req      = 4'b0011;
    update_data();
    run(6 * PERIOD - 2);
    mode = M_DROP;
    req  = '0;
    update_data();
    run(PERIOD + 4);

    // request arriving while a frame is in flight
    do_reset();
    spacing_on = 1'b1;
    bytes[0]   = 8'h55;
    req        = 4'b0001;
    update_data();
    run(100);
    bytes[3] = 8'h77;
    req[3]   = 1'b1;
    update_data();
    run(PERIOD + 10);

    // reset in the middle of a frame, then a fresh request
    do_reset();
    bytes[2] = 8'h99;
    req      = 4'b0100;
    update_data();
    run(40);
    rst = 1'b1;
    cycle();
    rst      = 1'b0;
    bytes[1] = 8'h3C;
    req      = 4'b0010;
    update_data();
    run(PERIOD + 10);

    // back-to-back sweep of every byte value from one source
    do_reset();
    rx.delete();
    mode       = M_SWEEP;
    spacing_on = 1'b1;
    bytes[0]   = 8'h00;
    req        = 4'b0001;
    update_data();
    run(256 * PERIOD + 10);
    check("sweep_count", 32'(rx.size()), 32'd256);
    for (int k = 0; k < 256 && k < rx.size(); k++) check("sweep_byte", 32'(rx[k]), 32'(k));

    // random traffic with occasional resets
    do_reset();
    mode = M_RAND;
    run(30000);
    rst = 1'b0;
    mode = M_DROP;
    req  = '0;
    update_data();
    run(PERIOD + 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one uart_send transmitter between NUM_REQ byte producers using round-robin arbitration. uart_send exposes no busy flag, so this block times each frame itself and sequences send_trigger. It sits directly in front of uart_send; its data/send_trigger outputs drive uart_send's data/send_trigger inputs.

Parameters:
baudRate, 115200, line baud rate; must match the uart_send instance
clkFreq, 100000000, clk frequency in Hz; must match the uart_send instance
NUM_REQ, 4, number of requesters (2..8)
GUARD_CYCLES, 20, idle clocks appended after each 10-bit frame before the next trigger

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
req  input  NUM_REQ  per-requester level request; bit i asserted = reqData byte i is valid
reqData  input  8*NUM_REQ  requester bytes; byte i = reqData[8*i+7:8*i]
grant  output  NUM_REQ  one-cycle one-hot pulse: byte of requester i captured
data  output  8  byte to uart_send; held stable from trigger through end of frame
send_trigger  output  1  one-cycle pulse to uart_send
busy  output  1  high whenever state != IDLE

Behaviour:
- One clock domain (clk); reset is synchronous and active-high on rst. All outputs are registered.
- Derived constants: BIT_CYCLES = clkFreq/baudRate (integer division); FRAME_CYCLES = 10*BIT_CYCLES + GUARD_CYCLES. Defaults give 868 and 8700. Counter width = clog2(FRAME_CYCLES).
- Reset: state=IDLE, grant=0, send_trigger=0, data=8'h00, busy=0, rrPtr=0, counter=0. Reset takes priority over every other event. Reset mid-frame returns to IDLE on the next edge and does not abort a frame already on the line; the system resets uart_send on the same rst.
- States:
  - IDLE: if any req bit is high, select the first asserted index scanning rrPtr, rrPtr+1, ... mod NUM_REQ. Register data <= reqData byte of the winner, grant[winner] <= 1, send_trigger <= 1, go to TRIGGER. If no req bit is high, stay in IDLE.
  - TRIGGER (exactly 1 cycle, grant and send_trigger high here): on the next edge clear grant and send_trigger, set counter=0, set rrPtr = (winner+1) mod NUM_REQ, go to WAIT.
  - WAIT: counter increments each cycle. When counter == FRAME_CYCLES-1, go to IDLE. req is ignored in WAIT.
- Latency: req sampled high in IDLE at edge k -> grant and send_trigger high during cycle k+1 -> back in IDLE at k+2+FRAME_CYCLES.
- Back-to-back throughput: trigger-to-trigger spacing is FRAME_CYCLES+2 = 8702 clocks at defaults.
- Handshake rules:
  - A requester holds req and its byte stable until it sees its grant pulse.
  - A requester that still has req high in the cycle after grant is presenting a new byte; that byte is arbitrated normally.
  - Dropping req before grant withdraws the byte with no side effects.
- data changes only in the IDLE -> TRIGGER transition.
- Simultaneous requests: exactly one grant per frame. Round-robin guarantees each continuously requesting source is served within NUM_REQ frames.

Test Plan:
- Single request: defaults; req=4'b0100, byte2=8'hA5 from edge 0 -> grant=4'b0100 and send_trigger high for exactly one cycle at cycle 1 with data=8'hA5; uart_recv reports 8'hA5; busy falls after 8701 cycles.
- All requesting: req=4'b1111 held until each source's grant, bytes 8'h10..8'h13 -> grants in order 0,1,2,3; triggers 8702 clocks apart; receiver gets 8'h10, 8'h11, 8'h12, 8'h13; no double grant.
- Fairness: req0 held high permanently, req1 pulsed high again after each of its grants -> grant sequence 0,1,0,1,0,1; source 0 never wins twice in a row while req1 is pending.
- Request during WAIT: req3 rises 100 cycles after a trigger -> no grant and no trigger until IDLE is reached; trigger for source 3 occurs exactly 8702 clocks after the previous trigger.
- Reset mid-frame: rst high for 1 cycle at counter=4000 -> next cycle busy=0, grant=0, send_trigger=0, data=8'h00; a following req=4'b0010 with 8'h3C is granted (rrPtr=0 scan) and received after uart_send idles.
- Sweep: single requester sends 8'h00..8'hFF back-to-back -> all 256 bytes are received in order with exact 8702-clock trigger spacing.
